// File: rtl/adder_response_checker.sv
// adder_response_checker: response-side checker for the adder test harness.
// Accepts one applied vector plus the adder's response per cycle, recomputes
// the expected sum/carry one stage later, keeps pass/fail statistics, records
// the first failing vector and compacts every response into a rotate-XOR
// signature.
module adder_response_checker #(
    parameter int unsigned n           = 64,
    parameter int unsigned num_vectors = 30000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           in_valid,
    input  logic           cin,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic [n-1:0]   s_duv,
    input  logic           cout_duv,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [31:0]    vec_count,
    output logic [31:0]    err_count,
    output logic [31:0]    first_err_idx,
    output logic [n-1:0]   first_err_s,
    output logic [n:0]     signature
);

    localparam logic [31:0] NV = 32'(num_vectors);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // stage-1 (accept) registers
    logic           v1_q, v1_d;
    logic [31:0]    accept_cnt_q, accept_cnt_d;
    logic [n-1:0]   a1_q, a1_d;
    logic [n-1:0]   b1_q, b1_d;
    logic           cin1_q, cin1_d;
    logic [n-1:0]   s1_q, s1_d;
    logic           cout1_q, cout1_d;

    // stage-2 (check) results
    logic [31:0]    vec_count_q, vec_count_d;
    logic [31:0]    err_count_q, err_count_d;
    logic [31:0]    first_err_idx_q, first_err_idx_d;
    logic [n-1:0]   first_err_s_q, first_err_s_d;
    logic [n:0]     sig_q, sig_d;

    logic [n:0]     exp_sum;
    logic [n:0]     resp;
    logic           mismatch;

    // Expected result recomputed from the stage-1 registers
    always_comb begin
        exp_sum  = {1'b0, a1_q} + {1'b0, b1_q} + {{n{1'b0}}, cin1_q};
        resp     = {cout1_q, s1_q};
        mismatch = (resp != exp_sum);
    end

    // Next-state logic for the FSM, accept stage and check stage
    always_comb begin
        state_d         = state_q;
        v1_d            = 1'b0;
        accept_cnt_d    = accept_cnt_q;
        a1_d            = a1_q;
        b1_d            = b1_q;
        cin1_d          = cin1_q;
        s1_d            = s1_q;
        cout1_d         = cout1_q;
        vec_count_d     = vec_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        first_err_s_d   = first_err_s_q;
        sig_d           = sig_q;

        if (start && (state_q != RUN)) begin
            // the edge that enters RUN clears everything and accepts nothing
            state_d         = RUN;
            accept_cnt_d    = '0;
            vec_count_d     = '0;
            err_count_d     = '0;
            first_err_idx_d = '0;
            first_err_s_d   = '0;
            sig_d           = '0;
        end else if (state_q == RUN) begin
            if (v1_q) begin
                vec_count_d = vec_count_q + 32'd1;
                sig_d       = {sig_q[n-1:0], sig_q[n]} ^ resp;
                if (mismatch) begin
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + 32'd1;
                    end
                    if (err_count_q == '0) begin
                        first_err_idx_d = vec_count_q;
                        first_err_s_d   = s1_q;
                    end
                end
                if (vec_count_d == NV) begin
                    state_d = DONE;
                end
            end
            if (in_valid && (accept_cnt_q < NV)) begin
                v1_d         = 1'b1;
                accept_cnt_d = accept_cnt_q + 32'd1;
                a1_d         = a;
                b1_d         = b;
                cin1_d       = cin;
                s1_d         = s_duv;
                cout1_d      = cout_duv;
            end
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            v1_q            <= 1'b0;
            accept_cnt_q    <= '0;
            a1_q            <= '0;
            b1_q            <= '0;
            cin1_q          <= 1'b0;
            s1_q            <= '0;
            cout1_q         <= 1'b0;
            vec_count_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            first_err_s_q   <= '0;
            sig_q           <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            v1_q            <= v1_d;
            accept_cnt_q    <= accept_cnt_d;
            a1_q            <= a1_d;
            b1_q            <= b1_d;
            cin1_q          <= cin1_d;
            s1_q            <= s1_d;
            cout1_q         <= cout1_d;
            vec_count_q     <= vec_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_s_q   <= first_err_s_d;
            sig_q           <= sig_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = done_q && (err_count_q == '0);
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_s   = first_err_s_q;
    assign signature     = sig_q;

endmodule
